// File: rtl/qsfp_i2c_mon_pkg.sv
// Shared encodings for the QSFP I2C bus monitor: event types and FSM states,
// also used by the ILA/register decode.
package qsfp_i2c_mon_pkg;

    typedef enum logic [2:0] {
        EVT_START   = 3'd0,
        EVT_RSTART  = 3'd1,
        EVT_STOP    = 3'd2,
        EVT_BYTE    = 3'd3,
        EVT_TIMEOUT = 3'd4
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2
    } mon_state_e;

    localparam int BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Metastability synchronizer followed by a glitch filter for one I2C line.
// The filtered output idles high and only follows a run of FILTER_LEN new samples.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          run_cnt;
    logic                   sample;

    assign sample = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Any sample agreeing with the current output restarts the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout    <= 1'b1;
            run_cnt <= '0;
        end else if (sample == dout) begin
            run_cnt <= '0;
        end else if (run_cnt == CNT_LAST) begin
            dout    <= sample;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qsfp_i2c_bus_monitor.sv
// Passive QSFP management-bus I2C observer: decodes START/RSTART/STOP/BYTE/TIMEOUT
// into a registered one-cycle event stream and keeps saturating statistics.
module qsfp_i2c_bus_monitor
    import qsfp_i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 sda_i,
    input  logic                 scl_i,
    input  logic                 clr_cnt,
    output logic                 evt_valid,
    output logic [2:0]           evt_type,
    output logic [7:0]           evt_byte,
    output logic                 evt_ack,
    output logic                 evt_first,
    output logic                 bus_busy,
    output logic [CNT_WIDTH-1:0] byte_cnt,
    output logic [CNT_WIDTH-1:0] nack_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          scl;
    logic          sda;
    logic          scl_q;
    logic          sda_q;
    logic          start_cond;
    logic          stop_cond;
    logic          scl_rise;
    logic          timeout_hit;

    mon_state_e    state;
    mon_state_e    state_next;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          first_flag;
    logic [TW-1:0] to_cnt;

    logic          evt_valid_d;
    evt_type_e     evt_type_d;
    logic [7:0]    evt_byte_d;
    logic          evt_ack_d;
    logic          evt_first_d;
    logic          byte_inc;
    logic          nack_inc;
    logic          err_inc;

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .din   (scl_i),
        .dout  (scl)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .din   (sda_i),
        .dout  (sda)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    // Requiring SCL high in both cycles makes simultaneous SCL/SDA changes plain clock edges.
    assign start_cond  = scl && scl_q && sda_q && !sda;
    assign stop_cond   = scl && scl_q && !sda_q && sda;
    assign scl_rise    = scl && !scl_q;
    assign timeout_hit = (state != ST_IDLE) && !scl && (to_cnt == TO_LAST);
    assign bus_busy    = (state != ST_IDLE);

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start_cond) state_next = ST_SHIFT;
            end
            ST_SHIFT, ST_ACK: begin
                if (stop_cond) begin
                    state_next = ST_IDLE;
                end else if (start_cond) begin
                    state_next = ST_SHIFT;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (scl_rise) begin
                    if (state == ST_ACK) begin
                        state_next = ST_SHIFT;
                    end else if (bit_cnt == 4'(BYTE_BITS - 1)) begin
                        state_next = ST_ACK;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        evt_valid_d = 1'b0;
        evt_type_d  = EVT_START;
        evt_byte_d  = '0;
        evt_ack_d   = 1'b0;
        evt_first_d = 1'b0;
        byte_inc    = 1'b0;
        nack_inc    = 1'b0;
        err_inc     = 1'b0;
        if (stop_cond) begin
            evt_valid_d = 1'b1;
            evt_type_d  = EVT_STOP;
            err_inc     = (state != ST_IDLE) && ((bit_cnt != 4'd0) || (state == ST_ACK));
        end else if (start_cond) begin
            evt_valid_d = 1'b1;
            evt_type_d  = (state == ST_IDLE) ? EVT_START : EVT_RSTART;
            evt_first_d = 1'b1;
            err_inc     = (state != ST_IDLE) && (bit_cnt != 4'd0);
        end else if (timeout_hit) begin
            evt_valid_d = 1'b1;
            evt_type_d  = EVT_TIMEOUT;
            err_inc     = 1'b1;
        end else if ((state == ST_ACK) && scl_rise) begin
            evt_valid_d = 1'b1;
            evt_type_d  = EVT_BYTE;
            evt_byte_d  = shreg;
            evt_ack_d   = !sda;
            evt_first_d = first_flag;
            byte_inc    = 1'b1;
            nack_inc    = sda;
        end
    end

    // Shift register, bit counter, address-byte flag and SCL-low watchdog.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            first_flag <= 1'b0;
            to_cnt     <= '0;
        end else begin
            to_cnt <= ((state != ST_IDLE) && !scl && !timeout_hit) ? to_cnt + 1'b1 : '0;
            if (start_cond) begin
                bit_cnt    <= '0;
                first_flag <= 1'b1;
            end else if (stop_cond || timeout_hit) begin
                bit_cnt <= '0;
            end else if (scl_rise) begin
                if (state == ST_SHIFT) begin
                    shreg   <= {shreg[6:0], sda};
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (state == ST_ACK) begin
                    bit_cnt    <= '0;
                    first_flag <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            evt_valid <= 1'b0;
            evt_type  <= '0;
            evt_byte  <= '0;
            evt_ack   <= 1'b0;
            evt_first <= 1'b0;
        end else begin
            evt_valid <= evt_valid_d;
            evt_type  <= evt_type_d;
            evt_byte  <= evt_byte_d;
            evt_ack   <= evt_ack_d;
            evt_first <= evt_first_d;
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn || clr_cnt) begin
            byte_cnt <= '0;
            nack_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (byte_inc && (byte_cnt != '1)) byte_cnt <= byte_cnt + 1'b1;
            if (nack_inc && (nack_cnt != '1)) nack_cnt <= nack_cnt + 1'b1;
            if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_qsfp_i2c_bus_monitor.sv
// Self-checking bench: drives I2C pin waveforms and compares the event stream
// and counters against a bit-queue model of the bus protocol.
module tb_qsfp_i2c_bus_monitor;
    import qsfp_i2c_mon_pkg::*;

    localparam int S    = 2;
    localparam int F    = 3;
    localparam int TO   = 50;
    localparam int CW   = 4;
    localparam int H    = 5;
    localparam int LAT  = S + F + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sda_i;
    logic          scl_i;
    logic          clr_cnt;
    logic          evt_valid;
    logic [2:0]    evt_type;
    logic [7:0]    evt_byte;
    logic          evt_ack;
    logic          evt_first;
    logic          bus_busy;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] nack_cnt;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    qsfp_i2c_bus_monitor #(
        .SYNC_STAGES (S),
        .FILTER_LEN  (F),
        .TIMEOUT_CYC (TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .sda_i         (sda_i),
        .scl_i         (scl_i),
        .clr_cnt       (clr_cnt),
        .evt_valid     (evt_valid),
        .evt_type      (evt_type),
        .evt_byte      (evt_byte),
        .evt_ack       (evt_ack),
        .evt_first     (evt_first),
        .bus_busy      (bus_busy),
        .byte_cnt      (byte_cnt),
        .nack_cnt      (nack_cnt),
        .err_cnt       (err_cnt)
    );

    typedef struct {
        logic [12:0] f;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];
    int  cyc = 0;
    int  idle_junk = 0;
    int  vectors = 0;
    int  miscompares = 0;

    bit  m_busy = 1'b0;
    bit  m_first = 1'b0;
    bit  m_bits[$];
    int  m_byte = 0;
    int  m_nack = 0;
    int  m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (evt_valid) begin
                ev_t e;
                e.f   = {evt_type, evt_byte, evt_ack, evt_first};
                e.cyc = cyc;
                got_q.push_back(e);
            end else if ({evt_type, evt_byte, evt_ack, evt_first} != 13'd0) begin
                idle_junk++;
            end
        end
    end

    function automatic int sat(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic push_exp(logic [2:0] t, logic [7:0] b, logic a, logic f, int at);
        ev_t e;
        e.f   = {t, b, a, f};
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Reference model: one call per bus-level condition observed on the pins.
    task automatic m_start(int c);
        push_exp(m_busy ? EVT_RSTART : EVT_START, 8'h00, 1'b0, 1'b1, c + LAT);
        if (m_busy && m_bits.size() != 0) m_err = sat(m_err);
        m_busy  = 1'b1;
        m_first = 1'b1;
        m_bits.delete();
    endtask

    task automatic m_stop(int c);
        push_exp(EVT_STOP, 8'h00, 1'b0, 1'b0, c + LAT);
        if (m_busy && m_bits.size() != 0) m_err = sat(m_err);
        m_busy = 1'b0;
        m_bits.delete();
    endtask

    task automatic m_rise(bit b, int c);
        logic [7:0] v;
        if (!m_busy) return;
        m_bits.push_back(b);
        if (m_bits.size() == 9) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], m_bits[i]};
            push_exp(EVT_BYTE, v, !m_bits[8], m_first, c + LAT);
            m_byte = sat(m_byte);
            if (m_bits[8]) m_nack = sat(m_nack);
            m_first = 1'b0;
            m_bits.delete();
        end
    endtask

    task automatic m_timeout(int fall_c);
        if (!m_busy) return;
        push_exp(EVT_TIMEOUT, 8'h00, 1'b0, 1'b0, fall_c + S + F + TO);
        m_err  = sat(m_err);
        m_busy = 1'b0;
        m_bits.delete();
    endtask

    task automatic m_clear();
        m_byte = 0;
        m_nack = 0;
        m_err  = 0;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin-level primitives; each starts and ends on a falling clock edge.
    task automatic clk_bit(bit b, int g = 0);
        scl_i = 1'b0;
        wait_cyc(H);
        if (g == 1) begin
            scl_i = 1'b1;
            wait_cyc(F - 1);
            scl_i = 1'b0;
            wait_cyc(H);
        end
        sda_i = b;
        wait_cyc(H);
        scl_i = 1'b1;
        m_rise(b, cyc);
        if (g == 3) begin
            wait_cyc(F);
            scl_i = 1'b0;
        end
        wait_cyc(H);
        if (g == 2) begin
            sda_i = !b;
            wait_cyc(F - 1);
            sda_i = b;
            wait_cyc(H);
        end
    endtask

    task automatic sda_edge(bit v);
        if (sda_i !== v) begin
            sda_i = v;
            if (v) m_stop(cyc);
            else   m_start(cyc);
        end
        wait_cyc(H);
    endtask

    task automatic send_start();
        if (sda_i === 1'b0) clk_bit(1'b1);
        sda_edge(1'b0);
    endtask

    task automatic send_stop();
        if (sda_i === 1'b1) clk_bit(1'b0);
        sda_edge(1'b1);
    endtask

    task automatic send_byte(logic [7:0] b, bit ack, bit glitchy = 1'b0);
        int g;
        for (int i = 7; i >= 0; i--) begin
            g = glitchy ? int'($urandom_range(0, 6)) : 0;
            if (g > 3) g = 0;
            clk_bit(b[i], g);
        end
        clk_bit(!ack);
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        wait_cyc(1);
        clr_cnt = 1'b0;
        m_clear();
        wait_cyc(1);
    endtask

    task automatic apply_stimulus_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        sda_i = 1'b1;
        scl_i = 1'b1;
        wait_cyc(8);
        m_busy = 1'b0;
        m_bits.delete();
        m_clear();
    endtask

    task automatic check_all(string tag);
        int n;
        wait_cyc(12);
        check_output({tag, "/evt_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s/evt%0d", tag, i), 32'(got_q[i].f), 32'(exp_q[i].f));
            check_output($sformatf("%s/evt%0d_cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
        end
        check_output({tag, "/bus_busy"}, 32'(bus_busy), 32'(m_busy));
        check_output({tag, "/byte_cnt"}, 32'(byte_cnt), m_byte);
        check_output({tag, "/nack_cnt"}, 32'(nack_cnt), m_nack);
        check_output({tag, "/err_cnt"}, 32'(err_cnt), m_err);
        check_output({tag, "/idle_fields"}, idle_junk, 0);
        got_q.delete();
        exp_q.delete();
        idle_junk = 0;
    endtask

    initial begin
        int fall_c;
        int kind;
        int nb;

        clr_cnt = 1'b0;
        sda_i   = 1'b1;
        scl_i   = 1'b1;
        apply_stimulus_reset();
        check_output("reset/evt_valid", 32'(evt_valid), 0);
        check_output("reset/bus_busy", 32'(bus_busy), 0);
        check_output("reset/counters", {byte_cnt, nack_cnt, err_cnt}, 0);
        rst_n = 1'b1;
        wait_cyc(H);
        check_all("reset_idle");

        $display("[TB] write transaction");
        send_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h12, 1'b1);
        send_stop();
        check_all("write");
        check_output("write/byte_cnt_const", 32'(byte_cnt), 2);
        check_output("write/err_cnt_const", 32'(err_cnt), 0);

        $display("[TB] read with repeated start");
        pulse_clr();
        send_start();
        send_byte(8'hA1, 1'b1);
        send_start();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h5C, 1'b0);
        send_stop();
        check_all("read");
        check_output("read/nack_cnt_const", 32'(nack_cnt), 1);

        $display("[TB] glitches mid-byte");
        send_start();
        clk_bit(1'b1);
        clk_bit(1'b0, 1);
        clk_bit(1'b1, 3);
        clk_bit(1'b0);
        clk_bit(1'b1, 2);
        clk_bit(1'b1, 1);
        clk_bit(1'b0, 2);
        clk_bit(1'b1);
        clk_bit(1'b0);
        send_stop();
        check_all("glitch");

        $display("[TB] stop after partial byte");
        pulse_clr();
        send_start();
        clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b1);
        clk_bit(1'b0);
        sda_edge(1'b1);
        check_all("partial_stop");
        check_output("partial_stop/err_const", 32'(err_cnt), 1);

        $display("[TB] SCL stuck low timeout");
        pulse_clr();
        send_start();
        scl_i  = 1'b0;
        fall_c = cyc;
        m_timeout(fall_c);
        wait_cyc(60);
        scl_i = 1'b1;
        wait_cyc(H);
        check_all("timeout");
        check_output("timeout/err_const", 32'(err_cnt), 1);
        sda_edge(1'b1);
        check_all("timeout_idle_stop");

        $display("[TB] clear coincident with byte");
        send_start();
        send_byte(8'h3C, 1'b1);
        check_all("pre_clr");
        for (int i = 7; i >= 0; i--) clk_bit(1'(8'h96 >> i));
        scl_i = 1'b0;
        wait_cyc(H);
        sda_i = 1'b0;
        wait_cyc(H);
        scl_i = 1'b1;
        m_rise(1'b0, cyc);
        wait_cyc(LAT - 1);
        clr_cnt = 1'b1;
        wait_cyc(1);
        clr_cnt = 1'b0;
        m_clear();
        wait_cyc(H);
        check_all("clr_coincident");
        send_stop();
        check_all("clr_stop");

        $display("[TB] reset mid-byte");
        send_start();
        clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b1);
        check_all("pre_reset");
        apply_stimulus_reset();
        rst_n = 1'b1;
        wait_cyc(H);
        send_start();
        send_byte(8'h50, 1'b1);
        send_stop();
        check_all("post_reset");

        $display("[TB] randomized transactions");
        for (int t = 0; t < 25; t++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 3) send_stop();
            if (kind == 2) begin
                send_start();
                nb = int'($urandom_range(0, 8));
                for (int i = 0; i < nb; i++) clk_bit(1'($urandom_range(0, 1)));
                send_stop();
            end else begin
                send_start();
                nb = int'($urandom_range(1, 3));
                for (int i = 0; i < nb; i++)
                    send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
                if ($urandom_range(0, 2) == 0) begin
                    send_start();
                    send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
                end
                send_stop();
            end
            check_all($sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
